// File: rtl/restoring_divider_if.sv
// Operand/result handshake bundle for the restoring divider.
// The master issues operands and accepts results; the slave is the divider.
interface restoring_divider_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first,
// with valid/ready handshakes on both the operand and the result side.
module restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  restoring_divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  // Dividend bits shift out at the MSB while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // A settled partial remainder is always below the divisor, so WIDTH bits hold it.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dq_step;

  // Trial subtraction at WIDTH+1 bits; its sign bit is the borrow.
  assign r_shift  = {rem_q, dq_q[WIDTH-1]};
  assign trial    = r_shift - {1'b0, dvs_q};
  assign borrow   = trial[WIDTH];
  assign rem_step = borrow ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign dq_step  = {dq_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d   = state_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dq_d  = bus.dividend;
          dvs_d = bus.divisor;
          rem_d = '0;
          if (bus.divisor == '0) begin
            state_d   = S_DONE;
            quo_out_d = '1;
            rem_out_d = bus.dividend;
            dbz_d     = 1'b1;
          end else begin
            state_d = S_CALC;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
      end
      S_CALC: begin
        dq_d  = dq_step;
        rem_d = rem_step;
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          quo_out_d = dq_step;
          rem_out_d = rem_step;
          dbz_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dq_q      <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quo_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases, reset abort and
// an exhaustive WIDTH=4 sweep against an arithmetic reference model.
module tb_restoring_divider;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  restoring_divider_if #(.WIDTH(W)) bus ();

  restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_q(input int unsigned a, input int unsigned b);
    return (b == 0) ? 32'((1 << W) - 1) : 32'(a / b);
  endfunction

  function automatic logic [31:0] ref_r(input int unsigned a, input int unsigned b);
    return (b == 0) ? 32'(a) : 32'(a % b);
  endfunction

  // One full transaction: accept, latency, result, optional backpressure, handoff.
  task automatic do_op(input int unsigned a, input int unsigned b,
                       input int unsigned hold, input bit scramble, input bit hold_valid);
    int unsigned cyc;
    logic [31:0] eq, er;
    eq = ref_q(a, b);
    er = ref_r(a, b);

    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);

    bus.in_valid = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    @(negedge clk);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);

    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      if (scramble) begin
        bus.in_valid  = 1'($urandom);
        bus.dividend  = W'($urandom);
        bus.divisor   = W'($urandom);
        bus.out_ready = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    // out_valid is visible the cycle after accept for a zero divisor,
    // and WIDTH clock edges after the accept edge otherwise.
    check("latency", 32'(cyc), (b == 0) ? 32'd1 : 32'(W + 1));
    check("quotient", 32'(bus.quotient), eq);
    check("remainder", 32'(bus.remainder), er);
    check("div_by_zero", 32'(bus.div_by_zero), (b == 0) ? 32'd1 : 32'd0);
    if (b != 0) begin
      check("invariant_sum", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
      check("invariant_rem_lt_div", 32'(32'(bus.remainder) < 32'(b)), 32'd1);
    end

    bus.out_ready = 1'b0;
    if (hold_valid) begin
      bus.in_valid = 1'b1;
      bus.dividend = W'(7);
      bus.divisor  = W'(2);
    end
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_quotient", 32'(bus.quotient), eq);
      check("hold_remainder", 32'(bus.remainder), er);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end

    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("handoff_out_valid", 32'(bus.out_valid), 32'd0);
    check("handoff_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(13, 3, 0, 1'b0, 1'b0);
    do_op(15, 1, 1, 1'b0, 1'b0);
    do_op(5, 7, 0, 1'b0, 1'b0);
    do_op(9, 0, 2, 1'b0, 1'b0);
    do_op(0, 5, 0, 1'b0, 1'b0);
    do_op(13, 3, 5, 1'b0, 1'b1);

    // Abort 14/2 partway through the calculation with an async reset pulse.
    bus.in_valid = 1'b1;
    bus.dividend = W'(14);
    bus.divisor  = W'(2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    do_op(14, 2, 0, 1'b0, 1'b0);

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_op(a, b, $urandom_range(0, 3), 1'b1, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
